alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Adds valid/ready handshakes on input and output, and a registered result and Zero flag.
- Adds new ops: SRA, signed SLT and an iterative shift-add MUL.
- Sits between the register-read stage and writeback/branch resolution; a multi-cycle MUL stalls upstream through in_ready.

Parameters:
- WIDTH, 64: operand/result width; minimum 8; power of two.
- SHW, $clog2(WIDTH): shift-amount width; taken from B[SHW-1:0].
- TAG_W, 5: width of the sideband tag (destination register index) carried with each op.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- A  in  WIDTH  first operand
- B  in  WIDTH  second operand
- ALUControl  in  4  operation select
- in_tag  in  TAG_W  sideband tag, returned unchanged
- out_valid  out  1  Result/Zero/out_tag valid
- out_ready  in  1  consumer takes result this cycle
- Result  out  WIDTH  registered result
- Zero  out  1  high when Result == 0; registered with Result
- out_tag  out  TAG_W  tag of the op that produced Result

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; out_valid=0; Result=0; Zero=0; out_tag=0; iteration counter=0; in_ready=0 while rst_n low.
  - Reset mid-MUL abandons the op; no result is produced.
- Encodings (wraparound arithmetic, all WIDTH bits):
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0100 XOR.
  - 1000 SLL; 1001 SRL; 1010 SRA (arithmetic shift, sign-fill).
  - 0111 SLT: Result = {0..,1} if $signed(A) < $signed(B), else 0.
  - 0011 MUL: low WIDTH bits of A*B; unsigned/signed-agnostic.
  - Any other code: Result=0.
- Accept rule: an op is accepted when in_valid && in_ready on a clock edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). A same-cycle drain and accept is allowed.
- Single-cycle ops: on accept, Result/Zero/out_tag load at that edge; out_valid=1 the next cycle. Latency 1; throughput 1 per cycle while out_ready=1.
- MUL on accept:
  - Capture multiplicand=A, multiplier=B and tag; clear the accumulator; state=MUL; counter=0; in_ready=0.
  - Each MUL cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++.
  - When counter reaches WIDTH-1 (the last add done), the next edge writes acc to Result with Zero and out_tag, sets out_valid=1 and returns state to IDLE.
  - Accept-to-out_valid = WIDTH+1 cycles.
  - Early termination: when multiplier becomes 0, finish on the next edge. Verification checks values, not exact MUL latency beyond the upper bound WIDTH+1.
  - MUL is not started while out_valid=1 && !out_ready (in_ready gates it).
- Output hold: while out_valid && !out_ready, Result, Zero and out_tag are stable. out_valid falls on the edge where out_ready=1 unless a new single-cycle op is accepted on that same edge.
- in_valid while in_ready=0: ignored. The producer must hold its inputs; the block does not buffer.
- No combinational path from A/B to Result; in_ready depends only on state, out_valid and out_ready.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: MUL (0011) is implemented as above with the MUL state.
- Undefined: no MUL state or iterative hardware; 0011 is treated as an undefined code. It completes in 1 cycle with Result=0, Zero=1 and in_ready never drops for it.

Test Plan:
- Reset: assert rst_n=0 mid-stream → out_valid=0, Result=0, Zero=0 immediately (asynchronous); after release, in_ready=1.
- Back-to-back ALU ops, out_ready=1, WIDTH=64:
  - ADD 5+7, then SUB 7-7, then SRA 0x8000_0000_0000_0000>>4, on consecutive cycles.
  - Expect results 12 (Zero=0), 0 (Zero=1) and 0xF800_0000_0000_0000 on consecutive cycles, tags preserved.
- SLT signed: A=-1 (all ones), B=1 → Result=1; A=1, B=-1 → Result=0; ADD 0xFFFF_FFFF_FFFF_FFFF+1 → Result=0, Zero=1 (wrap).
- Backpressure: out_ready=0 for 3 cycles after an XOR 0xF0^0xFF → Result=0x0F held stable, in_ready=0, a second in_valid is not accepted; out_ready=1 → the second op is accepted on that edge.
- MUL (ALU_PIPE_MUL_EN defined):
  - 0x1234*0x10 → Result=0x12340, within ≤65 cycles, in_ready=0 throughout.
  - 0xFFFF_FFFF_FFFF_FFFF*2 → 0xFFFF_FFFF_FFFF_FFFE.
  - Reset pulse mid-MUL → no out_valid.
- MUL undefined (macro off): 0011 with A=3, B=4 → Result=0, Zero=1, latency 1 cycle.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes, signed SLT, SRA and optional iterative MUL.
// Latency: 1 cycle for single-cycle ops; MUL completes within WIDTH+1 cycles of accept.
// Backpressure: in_ready drops while a MUL iterates or while a held result is not drained.
//
// Optional feature macro: ALU_PIPE_MUL_EN enables the shift-add multiplier for code 0011.
// Without it, 0011 behaves as an undefined code (Result=0, Zero=1, one cycle).
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      operation handshake (A, B, ALUControl, in_tag)
//   out_valid / out_ready    result handshake (Result, Zero, out_tag)
//   Result, Zero, out_tag    registered outputs, stable while out_valid && !out_ready
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0011;
`endif

    // Single-cycle datapath; MUL and undefined codes fall to zero here.
    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        logic [WIDTH-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = WIDTH'($signed(a) >>> sh);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic [WIDTH-1:0] acc_sum;

    assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
`else
    assign in_ready = rst_n && (!out_valid_q || out_ready);
`endif

    assign accept    = in_valid && in_ready;
    assign alu_res   = alu_f(ALUControl, A, B);
    assign out_valid = out_valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign out_tag   = tag_q;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        tag_d       = tag_q;
        // A drained result drops valid unless something new loads below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
`ifdef ALU_PIPE_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mtag_d   = mtag_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ALUControl == OP_MUL) begin
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mtag_d   = in_tag;
                        state_d  = ST_MUL;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        tag_d       = in_tag;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                // Finish on the last bit, or early once no set multiplier bits remain.
                // out_valid is already low here: MUL only starts with the output slot free.
                if ((cnt_q == SHW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0)) begin
                    result_d    = acc_sum;
                    zero_d      = (acc_sum == '0);
                    tag_d       = mtag_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        if (accept) begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            tag_d       = in_tag;
            out_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            tag_q       <= '0;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mtag_q      <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            tag_q       <= tag_d;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mtag_q      <= mtag_d;
`endif
        end
    end

endmodule
